radix2_div: RTL and testbench

RADIX2_DIV -- requirements
Module: radix2_div

---
 rtl/radix2_div_pkg.sv | 27 ++
 rtl/radix2_div.sv | 145 ++++++++++++++
 tb/tb_radix2_div.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/radix2_div_pkg.sv
// Shared encodings for the radix-2 divider: FSM states, request/result
// handshake levels and the iteration count.
package radix2_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // One quotient bit per DivOn cycle; the counter reaching this value
    // marks the finishing (sign-apply) cycle.
    localparam logic [5:0] DIV_ITERS = 6'd32;

    // Two's-complement magnitude of a 32-bit value when neg is set.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/radix2_div.sv
// Multi-cycle 32-bit restoring divider (signed DIV / unsigned DIVU).
// Produces {remainder, quotient} 34 edges after the start edge, or 2 edges
// for a zero divisor.
//
// Handshake: start_i is a level request held by the initiator until it sees
// ready_o. ready_o stays high (result_o stable) while start_i stays high;
// once start_i drops, ready_o and result_o return to 0 on the next edge.
// annul_i aborts a running operation (DivOn/DivByZero) without ready_o.
import radix2_div_pkg::*;

module radix2_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output div_state_e  dbg_state_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;      // dividend magnitude, shifts out MSB-first; quotient shifts in
    logic [31:0] rem_q, rem_d;      // partial remainder
    logic [31:0] div_q, div_d;      // divisor magnitude
    logic        quot_neg_q, quot_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] step;
    logic        op1_neg;
    logic        op2_neg;

    // One restoring step. The partial remainder is below the divisor, so
    // {rem, bit} - divisor lies in (-2^32, 2^32) and a 33-bit difference
    // carries the correct sign. Returns {quotient_bit, next_remainder}.
    function automatic logic [32:0] trial_step(input logic [31:0] rem,
                                               input logic        bit_in,
                                               input logic [31:0] divisor);
        logic [32:0] diff;
        logic        ge;
        diff = {rem, bit_in} - {1'b0, divisor};
        ge   = ~diff[32];
        return {ge, ge ? diff[31:0] : {rem[30:0], bit_in}};
    endfunction

    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign step    = trial_step(rem_q, dvd_q[31], div_q);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = 64'h0;
                if (start_i == DIV_START && !annul_i) begin
                    quot_neg_d = op1_neg ^ op2_neg;
                    rem_neg_d  = op1_neg;
                    dvd_d      = magnitude(op1_neg, opdata1_i);
                    div_d      = magnitude(op2_neg, opdata2_i);
                    rem_d      = 32'h0;
                    cnt_d      = 6'd0;
                    state_d    = (opdata2_i == 32'h0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = 64'h0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = 6'd0;
                end else if (cnt_q == DIV_ITERS) begin
                    result_d = {magnitude(rem_neg_q, rem_q), magnitude(quot_neg_q, dvd_q)};
                    ready_d  = DIV_RESULT_READY;
                    cnt_d    = 6'd0;
                    state_d  = DIV_END;
                end else begin
                    rem_d = step[31:0];
                    dvd_d = {dvd_q[30:0], step[32]};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = 64'h0;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= 6'd0;
            dvd_q      <= 32'h0;
            rem_q      <= 32'h0;
            div_q      <= 32'h0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= 64'h0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_radix2_div.sv
// Directed bench for radix2_div: a table of operations with hand-computed
// results and latencies, plus annul and mid-operation reset sequences.
import radix2_div_pkg::*;

module tb_radix2_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    div_state_e  dbg_state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    radix2_div dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard helper
    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Driver: run one operation with start held, check latency, result,
    // hold behaviour in DivEnd and the release back to DivFree.
    task automatic run_op(input vec_t v);
        int  edges;
        bit  seen;
        @(negedge clk);
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        start_i      = 1'b1;
        edges        = 0;
        seen         = 1'b0;
        for (int e = 1; e <= 40 && !seen; e++) begin
            tick();
            edges = e;
            if (e == 1) begin
                // Operands changing after the start edge must not matter.
                signed_div_i = ~v.sgn;
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
            end
            if (ready_o) seen = 1'b1;
        end
        check64({v.name, " latency"}, 64'(edges), 64'(v.lat));
        check64({v.name, " result"}, result_o, v.exp);
        tick();
        tick();
        check64({v.name, " hold"}, {ready_o, result_o}, {1'b1, v.exp});
        start_i = 1'b0;
        tick();
        check64({v.name, " release"}, {ready_o, result_o, dbg_state_o}, {1'b0, 64'h0, DIV_FREE});
    endtask

    initial begin
        bit any_ready;

        vecs.push_back('{"u100_7",     1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34});
        vecs.push_back('{"s_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34});
        vecs.push_back('{"u_m7_2",     1'b0, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, 34});
        vecs.push_back('{"div0",       1'b0, 32'h12345678, 32'd0,        64'h0,                 2});
        vecs.push_back('{"s_div0",     1'b1, 32'h80000000, 32'd0,        64'h0,                 2});
        vecs.push_back('{"s_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34});
        vecs.push_back('{"u_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 34});
        vecs.push_back('{"s_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34});
        vecs.push_back('{"s_m7_m2",    1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 34});
        vecs.push_back('{"u_max_max",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 34});
        vecs.push_back('{"u_5_10",     1'b0, 32'd5,        32'd10,       64'h00000005_00000000, 34});
        vecs.push_back('{"s_min_2",    1'b1, 32'h80000000, 32'd2,        64'h00000000_C0000000, 34});
        vecs.push_back('{"u_min_2",    1'b0, 32'h80000000, 32'd2,        64'h00000000_40000000, 34});
        vecs.push_back('{"u_big",      1'b0, 32'hDEADBEEF, 32'h00010000, 64'h0000BEEF_0000DEAD, 34});

        // Reset
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        tick();
        tick();
        check64("reset", {ready_o, result_o, dbg_state_o}, {1'b0, 64'h0, DIV_FREE});
        start_i = 1'b0;
        rst     = 1'b0;
        tick();

        // Table-driven operations
        foreach (vecs[i]) run_op(vecs[i]);

        // Annul at iteration 10
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        check64("annul state", {ready_o, dbg_state_o}, {1'b0, DIV_FREE});
        annul_i   = 1'b0;
        any_ready = 1'b0;
        repeat (40) begin
            tick();
            if (ready_o) any_ready = 1'b1;
        end
        check64("annul no ready", 64'(any_ready), 64'h0);
        run_op('{"after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34});

        // Reset at iteration 20
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (21) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        check64("mid reset", {ready_o, result_o, dbg_state_o}, {1'b0, 64'h0, DIV_FREE});
        rst = 1'b0;
        run_op('{"after_rst_50_5", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 34});

        // Reset has priority over a start request
        @(negedge clk);
        rst       = 1'b1;
        start_i   = 1'b1;
        opdata2_i = 32'd3;
        any_ready = 1'b0;
        repeat (3) begin
            tick();
            if (ready_o || dbg_state_o != DIV_FREE) any_ready = 1'b1;
        end
        check64("rst priority", 64'(any_ready), 64'h0);
        rst     = 1'b0;
        start_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
